// File: rtl/seq_div.sv
// Multi-cycle restoring integer divider, one quotient bit per clock, signed or
// unsigned per operation, with valid/ready handshakes on both sides.
module seq_div #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         signed_mode,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int CNT_W = $clog2(N + 1);
   localparam logic [N-1:0] ONE     = N'(1);
   localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

   // Handshake: a transfer happens on any rising edge where valid and ready
   // are both high; out_valid holds with stable data until out_ready.
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [N-1:0]     mag_dv;
   logic [N-1:0]     dq;
   logic [N-1:0]     rem;
   logic [N-1:0]     dd_raw;
   logic             sign_q;
   logic             sign_r;
   logic             dbz;
   logic             ovf;
   logic [CNT_W-1:0] cnt;

   logic [N-1:0]     mag_dd_in;
   logic [N-1:0]     mag_dv_in;
   logic [N:0]       rem_sh;
   logic [N:0]       trial;

   always_comb begin
      mag_dd_in = (signed_mode && dividend[N-1]) ? (~dividend) + ONE : dividend;
      mag_dv_in = (signed_mode && divisor[N-1])  ? (~divisor) + ONE  : divisor;
      rem_sh    = {rem, dq[N-1]};
      trial     = rem_sh - {1'b0, mag_dv};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         mag_dv      <= '0;
         dq          <= '0;
         rem         <= '0;
         dd_raw      <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dbz         <= 1'b0;
         ovf         <= 1'b0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mag_dv   <= mag_dv_in;
                  dq       <= mag_dd_in;
                  rem      <= '0;
                  dd_raw   <= dividend;
                  sign_q   <= signed_mode & (dividend[N-1] ^ divisor[N-1]);
                  sign_r   <= signed_mode & dividend[N-1];
                  dbz      <= (divisor == '0);
                  ovf      <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
                  cnt      <= CNT_W'(N);
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               // The dividend shifts out of dq while quotient bits shift in.
               if (!trial[N]) begin
                  rem <= trial[N-1:0];
                  dq  <= {dq[N-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[N-1:0];
                  dq  <= {dq[N-2:0], 1'b0};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= FIX;
            end
            FIX: begin
               if (dbz) begin
                  quotient  <= '1;
                  remainder <= dd_raw;
               end else if (ovf) begin
                  quotient  <= MIN_VAL;
                  remainder <= '0;
               end else begin
                  quotient  <= sign_q ? (~dq) + ONE : dq;
                  remainder <= sign_r ? (~rem) + ONE : rem;
               end
               div_by_zero <= dbz;
               overflow    <= ovf & ~dbz;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (N=32): results, flags, fixed latency,
// back-pressure and mid-operation reset.
module tb_seq_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        signed_mode;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   seq_div #(.N(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Issue one operation at a negedge, then wait for out_valid; leaves the
   // bench at a negedge with the result pending and out_ready low.
   task automatic start_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                           input string tag, output int lat);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      signed_mode = sm;
      dividend    = a;
      divisor     = b;
      in_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input logic eovf, input string tag);
      int lat;
      start_op(sm, a, b, tag, lat);
      check({tag, "_latency"}, 32'(lat), 32'd33);
      check({tag, "_quot"}, quotient, eq);
      check({tag, "_rem"}, remainder, er);
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      check({tag, "_ovf"}, 32'(overflow), 32'(eovf));
      finish_op();
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, "_hold_quot"}, quotient, eq);
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0;
      dividend = '0; divisor = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quot", quotient, 32'd0);
      check("rst_rem", remainder, 32'd0);

      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, "s_m7_d2");
      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "u_100_d7");
      run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, "u_ff_d2");
      run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "s_m1_d2");
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, "s_ovf");
      run_op(1'b1, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "s_7_dm7");
      run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, "u_dbz");
      run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, "s_dbz");
      run_op(1'b0, 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 1'b0, "u_6_d3");
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, "u_min_dff");

      // Back-pressure: result held while a new request is offered and ignored.
      start_op(1'b0, 32'd1000, 32'd10, "bp", lat);
      check("bp_latency", 32'(lat), 32'd33);
      signed_mode = 1'b1; dividend = 32'd77; divisor = 32'd5; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_quot_hold", quotient, 32'd100);
         check("bp_rem_hold", remainder, 32'd0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      finish_op();
      check("bp_ready_after", 32'(in_ready), 32'd1);
      check("bp_quot_after", quotient, 32'd100);

      // Reset in the middle of CALC aborts the operation.
      signed_mode = 1'b0; dividend = 32'd50; divisor = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_quot", quotient, 32'd0);
      check("abort_rem", remainder, 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      repeat (40) begin
         @(negedge clk);
         check("abort_no_result", 32'(out_valid), 32'd0);
      end
      run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0, "u_9_d4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle integer divider with a valid/ready handshake on both sides. It replaces single-cycle combinational division in the shape datapath.
- Produces quotient and remainder in signed (two's-complement) or unsigned mode, selected per operation.
- Uses one restoring-division step per clock. Latency is fixed.
- Flags divide-by-zero and signed overflow. Sits between the shape-geometry pipeline (slope, scaling and centroid computations) and its result registers.

Parameters:
- N, 32, operand/result width in bits; N >= 2.
- CNT_W, $clog2(N+1), iteration counter width; localparam, not overridable.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  dividend/divisor/signed_mode valid
- in_ready  output  1  divider can accept an operation
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
- dividend  input  N  numerator
- divisor  input  N  denominator
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- quotient  output  N  quotient, truncated toward zero
- remainder  output  N  remainder; sign follows the dividend in signed mode
- div_by_zero  output  1  divisor was 0 for this result
- overflow  output  1  signed MIN / -1 for this result

Behaviour:
- Reset: rst sampled high at a clock edge forces:
  - state IDLE
  - in_ready=1, out_valid=0
  - quotient=0, remainder=0, div_by_zero=0, overflow=0
  - internal operands and counter cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- States:
  - IDLE: in_ready=1. on in_valid, capture, go to CALC.
  - CALC: N iterations, then go to FIX.
  - FIX: sign correction and special cases, then go to DONE.
  - DONE: out_valid=1. on out_ready, go to IDLE.
  - in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Capture (edge where in_valid & in_ready):
  - store magnitudes: |x| = (~x)+1 when signed_mode & x[N-1], else x. MIN keeps bit pattern 1000..0, treated as unsigned 2^(N-1).
  - store sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend), both masked by signed_mode.
  - store dbz = (divisor==0) and ovf = signed_mode & dividend==MIN & divisor==all-ones.
  - load counter=N, partial remainder=0.
- CALC, one bit per edge, MSB first:
  - shift {rem, dq} left 1.
  - trial = rem - |divisor| on N+1 bits.
  - if trial is non-negative: rem=trial, quotient bit=1; else quotient bit=0.
  - counter decrements each edge; after exactly N CALC edges, go to FIX.
- FIX (one edge):
  - q = sign_q ? two's-complement negate of magnitude quotient : magnitude quotient.
  - r = sign_r ? two's-complement negate of remainder : remainder.
  - Override when dbz: quotient=all-ones, remainder=dividend as captured, div_by_zero=1.
  - Override when ovf: quotient=MIN, remainder=0, overflow=1.
  - dbz takes precedence; dbz and ovf never both set.
- Latency: out_valid rises N+1 edges after the accepting edge, e.g. 33 for N=32. This holds regardless of operand values, including dbz and ovf.
- Output hold: quotient, remainder and flags are registered and stable from the FIX edge until the next FIX edge. They remain readable after the handshake.
- Result accept: edge with out_valid & out_ready returns to IDLE, so in_ready=1 in the next cycle. The earliest back-to-back accept is one cycle after the result handshake; throughput is one operation per N+3 cycles.
- Changes to in_valid or the operands while not in IDLE are ignored.
- Unsigned mode: MSB is magnitude; ovf never set.

Test Plan:
- N=32, signed, -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1), flags 0; out_valid exactly 33 cycles after accept.
- Unsigned 100 / 7 -> quotient 14, remainder 2. Then bit pattern 0xFFFFFFFF / 2 unsigned -> quotient 0x7FFFFFFF, remainder 1; the same operands signed -> quotient 0, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow=1. Signed 7 / -7 -> quotient 0xFFFFFFFF, remainder 0.
- 5 / 0, both modes -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1, still 33-cycle latency. Next op 6 / 3 -> div_by_zero=0, quotient 2.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stable, in_ready=0, and new in_valid ignored.
  - out_ready=1 -> in_ready=1 on the following cycle.
- Reset: assert rst at CALC cycle 10, then release.
  - Next cycle in_ready=1, out_valid=0, all outputs 0.
  - Fresh 9 / 4 -> quotient 2, remainder 1.
